// File: rtl/seq_decoder.sv
//==============================================================================
// seq_decoder : registered N-to-2^N one-hot decoder with direct and scan modes
// Revision    : 1.0
//==============================================================================
`default_nettype none

module seq_decoder #(
  parameter int ADDR_WIDTH  = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       mode,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic                       start,
  output logic [(2**ADDR_WIDTH)-1:0] out,
  output logic [ADDR_WIDTH-1:0]      cur_addr,
  output logic                       busy,
  output logic                       done
);

  localparam int OUT_WIDTH = 2**ADDR_WIDTH;
  localparam int DW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int PW        = ADDR_WIDTH + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] POS_LAST   = PW'(OUT_WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state, state_nxt;
  logic [DW-1:0]         dwell, dwell_nxt;
  logic [PW-1:0]         pos, pos_nxt;
  logic [OUT_WIDTH-1:0]  out_nxt;
  logic [ADDR_WIDTH-1:0] cur_nxt;
  logic                  busy_nxt, done_nxt;
  logic                  scan_accept, dwell_end, last_pos;

  function automatic logic [OUT_WIDTH-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
    onehot    = '0;
    onehot[a] = 1'b1;
  endfunction

  assign scan_accept = start && mode && enable;
  assign dwell_end   = (dwell == DWELL_LAST);
  assign last_pos    = (pos == POS_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      dwell    <= '0;
      pos      <= '0;
      out      <= '0;
      cur_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      dwell    <= dwell_nxt;
      pos      <= pos_nxt;
      out      <= out_nxt;
      cur_addr <= cur_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (scan_accept) state_nxt = SCAN;
      SCAN:    if (enable && dwell_end && last_pos) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dwell_nxt = dwell;
    pos_nxt   = pos;
    out_nxt   = out;
    cur_nxt   = cur_addr;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (scan_accept) begin
          out_nxt   = onehot(address);
          cur_nxt   = address;
          busy_nxt  = 1'b1;
          dwell_nxt = '0;
          pos_nxt   = '0;
        end else if (enable) begin
          out_nxt = onehot(address);
          cur_nxt = address;
        end else begin
          out_nxt = '0;
        end
      end
      SCAN: begin
        if (!enable) begin
          // Pause: blank the output, freeze all scan state.
          out_nxt = '0;
        end else if (!dwell_end) begin
          dwell_nxt = dwell + DW'(1);
          out_nxt   = onehot(cur_addr);
        end else if (last_pos) begin
          // cur_addr keeps the last visited index.
          dwell_nxt = '0;
          pos_nxt   = pos + PW'(1);
          out_nxt   = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          dwell_nxt = '0;
          pos_nxt   = pos + PW'(1);
          cur_nxt   = cur_addr + ADDR_WIDTH'(1);
          out_nxt   = onehot(cur_addr + ADDR_WIDTH'(1));
        end
      end
      DONE: begin
        out_nxt  = '0;
        busy_nxt = 1'b0;
      end
      default: begin
        out_nxt  = '0;
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_decoder.sv
// Scoreboard bench for seq_decoder: 2-bit/hold-2 and 3-bit/hold-1 instances.
`default_nettype none

module tb_seq_decoder;

  typedef struct packed {
    logic [7:0] out;
    logic [2:0] cur;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       en_a = 1'b0, mode_a = 1'b0, start_a = 1'b0;
  logic [1:0] addr_a = '0;
  logic [3:0] out_a;
  logic [1:0] cur_a;
  logic       busy_a, done_a;

  logic       en_b = 1'b0, mode_b = 1'b0, start_b = 1'b0;
  logic [2:0] addr_b = '0;
  logic [7:0] out_b;
  logic [2:0] cur_b;
  logic       busy_b, done_b;

  exp_t qa[$];
  exp_t qb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  seq_decoder #(.ADDR_WIDTH(2), .HOLD_CYCLES(2)) dut_a (
    .clk(clk), .reset_n(rst_n), .enable(en_a), .mode(mode_a), .address(addr_a),
    .start(start_a), .out(out_a), .cur_addr(cur_a), .busy(busy_a), .done(done_a)
  );

  seq_decoder #(.ADDR_WIDTH(3), .HOLD_CYCLES(1)) dut_b (
    .clk(clk), .reset_n(rst_n), .enable(en_b), .mode(mode_b), .address(addr_b),
    .start(start_b), .out(out_b), .cur_addr(cur_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic stepa(input logic en, input logic md, input logic [1:0] ad, input logic st,
                       input logic [7:0] eo, input logic [2:0] ec, input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    en_a = en; mode_a = md; addr_a = ad; start_a = st;
    e.out = eo; e.cur = ec; e.busy = eb; e.done = ed;
    qa.push_back(e);
  endtask

  task automatic stepb(input logic en, input logic md, input logic [2:0] ad, input logic st,
                       input logic [7:0] eo, input logic [2:0] ec, input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    en_b = en; mode_b = md; addr_b = ad; start_b = st;
    e.out = eo; e.cur = ec; e.busy = eb; e.done = ed;
    qb.push_back(e);
  endtask

  // Monitor: each expected entry describes the outputs after the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_out",  {28'd0, out_a},  {24'd0, e.out});
        chk("a_cur",  {30'd0, cur_a},  {29'd0, e.cur});
        chk("a_busy", {31'd0, busy_a}, {31'd0, e.busy});
        chk("a_done", {31'd0, done_a}, {31'd0, e.done});
        chk("a_onehot0", {31'd0, $onehot0(out_a)}, 32'd1);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_out",  {24'd0, out_b},  {24'd0, e.out});
        chk("b_cur",  {29'd0, cur_b},  {29'd0, e.cur});
        chk("b_busy", {31'd0, busy_b}, {31'd0, e.busy});
        chk("b_done", {31'd0, done_b}, {31'd0, e.done});
        chk("b_onehot0", {31'd0, $onehot0(out_b)}, 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_out",  {28'd0, out_a}, 32'd0);
    chk("rst_cur",  {30'd0, cur_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Direct mode, enable gating, ignored starts
    stepa(1, 0, 2'd2, 0, 8'h04, 3'd2, 0, 0);
    stepa(0, 0, 2'd2, 0, 8'h00, 3'd2, 0, 0);
    stepa(1, 0, 2'd3, 0, 8'h08, 3'd3, 0, 0);
    stepa(1, 0, 2'd1, 1, 8'h02, 3'd1, 0, 0);
    stepa(0, 1, 2'd0, 1, 8'h00, 3'd1, 0, 0);

    // Scan from address 1, hold 2
    stepa(1, 1, 2'd1, 1, 8'h02, 3'd1, 1, 0);
    stepa(1, 0, 2'd1, 0, 8'h02, 3'd1, 1, 0);
    stepa(1, 0, 2'd1, 0, 8'h04, 3'd2, 1, 0);
    stepa(1, 0, 2'd1, 0, 8'h04, 3'd2, 1, 0);
    stepa(1, 0, 2'd1, 0, 8'h08, 3'd3, 1, 0);
    stepa(1, 0, 2'd1, 0, 8'h08, 3'd3, 1, 0);
    stepa(1, 0, 2'd1, 0, 8'h01, 3'd0, 1, 0);
    stepa(1, 0, 2'd1, 0, 8'h01, 3'd0, 1, 0);
    stepa(1, 0, 2'd1, 0, 8'h00, 3'd0, 0, 1);
    stepa(0, 0, 2'd1, 0, 8'h00, 3'd0, 0, 0);

    // Scan with a 3-cycle pause after the first 0100 cycle
    stepa(1, 1, 2'd1, 1, 8'h02, 3'd1, 1, 0);
    stepa(1, 0, 2'd1, 0, 8'h02, 3'd1, 1, 0);
    stepa(1, 0, 2'd1, 0, 8'h04, 3'd2, 1, 0);
    for (int i = 0; i < 3; i++) stepa(0, 0, 2'd1, 0, 8'h00, 3'd2, 1, 0);
    stepa(1, 0, 2'd1, 0, 8'h04, 3'd2, 1, 0);
    stepa(1, 0, 2'd1, 0, 8'h08, 3'd3, 1, 0);
    stepa(1, 0, 2'd1, 0, 8'h08, 3'd3, 1, 0);
    stepa(1, 0, 2'd1, 0, 8'h01, 3'd0, 1, 0);
    stepa(1, 0, 2'd1, 0, 8'h01, 3'd0, 1, 0);
    stepa(1, 0, 2'd1, 0, 8'h00, 3'd0, 0, 1);
    stepa(0, 0, 2'd1, 0, 8'h00, 3'd0, 0, 0);

    // Mid-scan start/address/mode disturbances are ignored
    stepa(1, 1, 2'd1, 1, 8'h02, 3'd1, 1, 0);
    stepa(1, 0, 2'd3, 1, 8'h02, 3'd1, 1, 0);
    stepa(1, 1, 2'd0, 1, 8'h04, 3'd2, 1, 0);
    stepa(1, 0, 2'd2, 1, 8'h04, 3'd2, 1, 0);
    stepa(1, 1, 2'd3, 0, 8'h08, 3'd3, 1, 0);
    stepa(1, 0, 2'd0, 1, 8'h08, 3'd3, 1, 0);
    stepa(1, 1, 2'd2, 1, 8'h01, 3'd0, 1, 0);
    stepa(1, 0, 2'd1, 1, 8'h01, 3'd0, 1, 0);
    stepa(1, 1, 2'd2, 1, 8'h00, 3'd0, 0, 1);
    // start held through DONE: ignored there, accepted on the following edge
    stepa(1, 1, 2'd2, 1, 8'h00, 3'd0, 0, 0);
    stepa(1, 1, 2'd2, 1, 8'h04, 3'd2, 1, 0);
    stepa(1, 0, 2'd2, 0, 8'h04, 3'd2, 1, 0);

    // Asynchronous reset between edges mid-scan
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out",  {28'd0, out_a}, 32'd0);
    chk("arst_busy", {31'd0, busy_a}, 32'd0);
    chk("arst_done", {31'd0, done_a}, 32'd0);
    chk("arst_cur",  {30'd0, cur_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stepa(1, 0, 2'd3, 0, 8'h08, 3'd3, 0, 0);
    stepa(1, 0, 2'd0, 0, 8'h01, 3'd0, 0, 0);
    stepa(0, 0, 2'd0, 0, 8'h00, 3'd0, 0, 0);

    // 3-bit, hold 1: scan from 7 wraps through 0..6
    stepb(1, 1, 3'd7, 1, 8'h80, 3'd7, 1, 0);
    for (int k = 0; k < 7; k++) stepb(1, 0, 3'd0, 0, 8'(1 << k), 3'(k), 1, 0);
    stepb(1, 0, 3'd0, 0, 8'h00, 3'd6, 0, 1);
    stepb(0, 0, 3'd0, 0, 8'h00, 3'd6, 0, 0);

    repeat (2) @(posedge clk);
    #3;
    chk("drain_a", qa.size(), 32'd0);
    chk("drain_b", qb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_decoder.md
Name: seq_decoder

Overview:
- Registered, parametrised N-to-2^N one-hot decoder with an enable input.
- Two modes:
  - Direct mode: a clocked version of the 2-to-4 decoder.
  - Scan mode: an autonomous sequencer that walks the one-hot output through every position, with a configurable dwell time per position.
- Drives write-enable and strobe fans in larger datapaths, such as register-file write select and round-robin polling.

Parameters:
- ADDR_WIDTH, 2, address bits; output width is OUT_WIDTH = 2**ADDR_WIDTH (legal range 1..6).
- HOLD_CYCLES, 1, enabled cycles each scan position is held (legal range >= 1).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  gates all outputs; in scan mode, also pauses the scan.
- mode  input  1  0 = direct, 1 = scan; sampled only when start is accepted.
- address  input  ADDR_WIDTH  direct-mode select, and scan-mode start position.
- start  input  1  scan request; single-cycle pulse or level.
- out  output  OUT_WIDTH  registered one-hot (or all-zero) decode.
- cur_addr  output  ADDR_WIDTH  index currently decoded; the last value is held when out = 0.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse marking scan completion.

Behaviour:
- Reset, asynchronous while reset_n = 0:
  - out = 0, cur_addr = 0, busy = 0, done = 0.
  - State = IDLE; dwell and position counters = 0.
  - Reset mid-scan aborts immediately with no done pulse.
- States: IDLE, SCAN, DONE. All outputs are registered.
- IDLE, direct operation (each rising edge):
  - out <= enable ? (1 << address) : 0.
  - cur_addr <= address when enable = 1.
  - Latency is one clock from input to out.
- IDLE to SCAN: on an edge with start = 1, mode = 1 and enable = 1.
  - Same edge: out <= 1 << address; cur_addr <= address; busy <= 1; dwell counter <= 0; positions_done <= 0.
  - start with mode = 0 is ignored (direct operation continues).
  - start with enable = 0 is ignored.
- SCAN, enable = 1 (each edge):
  - Dwell counter increments.
  - When dwell reaches HOLD_CYCLES-1 on an edge: dwell counter <= 0; positions_done increments; cur_addr <= cur_addr + 1, wrapping modulo OUT_WIDTH (e.g. 3 -> 0 for ADDR_WIDTH = 2).
  - out follows cur_addr one-hot.
- SCAN, enable = 0 (pause):
  - out <= 0 on the next edge.
  - Dwell counter, position counter and cur_addr freeze.
  - When enable returns to 1, out <= 1 << cur_addr on the next edge, and the dwell for that position restarts from where it was frozen.
  - Paused cycles do not count toward HOLD_CYCLES.
- Scan length: exactly OUT_WIDTH positions, each held HOLD_CYCLES enabled cycles, starting at the start address. Total = OUT_WIDTH * HOLD_CYCLES enabled cycles.
- SCAN to DONE: on the edge that completes the final position's dwell.
  - Same edge: out <= 0; busy <= 0; done <= 1.
  - cur_addr holds the last visited index, i.e. start address - 1 modulo OUT_WIDTH.
- DONE to IDLE: unconditionally on the next edge; done <= 0.
- Ignored inputs:
  - start is ignored in SCAN and in DONE; a start asserted during DONE takes effect on the following edge if still high.
  - address and mode changes during SCAN or DONE are ignored.
- Edge case: OUT_WIDTH = 2 with HOLD_CYCLES = 1 produces a scan lasting 2 cycles.
- Invariant: out never has more than one bit set.

Test Plan:
1. ADDR_WIDTH=2, direct mode; enable=1, address=2; one edge later enable=0 -> out=4'b0100 one cycle after the address is applied; out=4'b0000 one edge after enable drops.
2. ADDR_WIDTH=2, HOLD_CYCLES=2; mode=1, start pulse with address=1 -> out is 0010,0010,0100,0100,1000,1000,0001,0001 on consecutive cycles. Then out=0000 with done=1 for one cycle and busy=0; cur_addr=0.
3. ADDR_WIDTH=2, HOLD_CYCLES=2, same scan as test 2 but enable=0 for 3 cycles after the first 0100 cycle -> out=0000 for those 3 cycles, then one more 0100 cycle, then 1000. Total scan = 8 enabled cycles.
4. Mid-scan: start re-pulsed, and address/mode changed -> sequence unchanged, exactly one done pulse.
5. reset_n driven low asynchronously (between clock edges) mid-scan -> out=0, busy=0, done=0 immediately with no clock edge; after release, direct mode is operational.
6. ADDR_WIDTH=3, HOLD_CYCLES=1; start at address=7 -> out walks bits 7,0,1,...,6 over 8 cycles, then done; check one-hot on every cycle.
